// File: rtl/ball_round_if.sv
// Signal bundle between the round sequencer and the button, physics and display logic.
// The master side is the sequencer, and the slave side is everything around it.
interface ball_round_if;
  logic        start;
  logic        pause;
  logic        win;
  logic        phys_tick;
  logic        pos_rst_n;
  logic [10:0] init_x;
  logic [10:0] init_y;
  logic [10:0] score_x;
  logic [10:0] score_y;
  logic [1:0]  level;
  logic [7:0]  time_left;
  logic [2:0]  state;
  logic        game_over;

  modport master (
    input  start, pause, win,
    output phys_tick, pos_rst_n, init_x, init_y, score_x, score_y,
           level, time_left, state, game_over
  );

  modport slave (
    output start, pause, win,
    input  phys_tick, pos_rst_n, init_x, init_y, score_x, score_y,
           level, time_left, state, game_over
  );
endinterface

// File: rtl/ball_round_ctrl.sv
// Round sequencer for the balance-board ball game.
// It issues the physics step strobe, runs the round timer, and steps through levels on each win.
module ball_round_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int SEC_TICKS  = 100,
  parameter int TIME_LIMIT = 60,
  parameter int WIN_HOLD   = 150,
  parameter int LEVELS     = 4
) (
  input  logic         clk,
  input  logic         rst,
  ball_round_if.master bus
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = ($clog2(SEC_TICKS) > 8) ? $clog2(SEC_TICKS) : 8;
  localparam int HOLD_W = ($clog2(WIN_HOLD) > 8) ? $clog2(WIN_HOLD) : 8;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(WIN_HOLD - 1);
  localparam logic [7:0]        TIME_INIT  = 8'(TIME_LIMIT);
  localparam logic [1:0]        LEVEL_LAST = 2'(LEVELS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_PLAY     = 3'd2;
  localparam logic [2:0] S_PAUSE    = 3'd3;
  localparam logic [2:0] S_WIN_HOLD = 3'd4;
  localparam logic [2:0] S_LOSE     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [7:0]        time_q, time_d;
  logic [DIV_W-1:0]  div_q, div_d, div_inc;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              load_q, load_d;
  logic              tick_q;
  logic              div_wrap;
  logic              timeout;
  logic              enter_load;
  logic [1:0]        load_level;

  // Next-state logic. Every way into LOAD shares one path that reloads the timer and clears the counters.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    time_d     = time_q;
    div_d      = div_q;
    sec_d      = sec_q;
    hold_d     = hold_q;
    load_d     = load_q;
    timeout    = 1'b0;
    enter_load = 1'b0;
    load_level = level_q;
    div_wrap   = (div_q == DIV_LAST);
    div_inc    = div_wrap ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          enter_load = 1'b1;
          load_level = 2'd0;
        end
      end
      S_LOAD: begin
        if (load_q) state_d = S_PLAY;
        else        load_d  = 1'b1;
      end
      S_PLAY: begin
        div_d = div_inc;
        if (div_wrap) begin
          if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (time_q != 8'd0) begin
              time_d  = time_q - 8'd1;
              timeout = (time_q == 8'd1);
            end
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
        if (bus.win)       state_d = S_WIN_HOLD;
        else if (timeout)  state_d = S_LOSE;
        else if (bus.pause) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (!bus.pause) state_d = S_PLAY;
      end
      S_WIN_HOLD: begin
        div_d = div_inc;
        if (div_wrap) begin
          if (hold_q == HOLD_LAST) begin
            if (level_q >= LEVEL_LAST) begin
              state_d = S_DONE;
            end else begin
              enter_load = 1'b1;
              load_level = level_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      S_LOSE: begin
        time_d = 8'd0;
        if (bus.start) enter_load = 1'b1;
      end
      S_DONE: begin
        if (bus.start) begin
          enter_load = 1'b1;
          load_level = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_load) begin
      state_d = S_LOAD;
      level_d = load_level;
      time_d  = TIME_INIT;
      div_d   = '0;
      sec_d   = '0;
      hold_d  = '0;
      load_d  = 1'b0;
    end
  end

  // The tick register is loaded from the next-state values, so it goes high in the same cycle the divider shows its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= 2'd0;
      time_q  <= TIME_INIT;
      div_q   <= '0;
      sec_q   <= '0;
      hold_q  <= '0;
      load_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      time_q  <= time_d;
      div_q   <= div_d;
      sec_q   <= sec_d;
      hold_q  <= hold_d;
      load_q  <= load_d;
      tick_q  <= (state_d == S_PLAY) && (div_d == DIV_LAST);
    end
  end

  always_comb begin
    bus.init_x  = 11'd40;
    bus.init_y  = 11'd40;
    bus.score_x = 11'd600;
    bus.score_y = 11'd440;
    case (level_q)
      2'd1: begin
        bus.init_x  = 11'd600;
        bus.init_y  = 11'd40;
        bus.score_x = 11'd40;
        bus.score_y = 11'd440;
      end
      2'd2: begin
        bus.init_x  = 11'd320;
        bus.init_y  = 11'd40;
        bus.score_x = 11'd320;
        bus.score_y = 11'd440;
      end
      2'd3: begin
        bus.init_x  = 11'd40;
        bus.init_y  = 11'd240;
        bus.score_x = 11'd600;
        bus.score_y = 11'd240;
      end
      default: ;
    endcase
  end

  assign bus.phys_tick = tick_q;
  assign bus.pos_rst_n = !((state_q == S_IDLE) || (state_q == S_LOAD));
  assign bus.game_over = (state_q == S_LOSE) || (state_q == S_DONE);
  assign bus.state     = state_q;
  assign bus.level     = level_q;
  assign bus.time_left = time_q;

endmodule

// File: tb/tb_ball_round_ctrl.sv
// Testbench for ball_round_ctrl. Directed sequences and random stimulus are checked
// cycle by cycle against a behavioural model of the game rules.
module tb_ball_round_ctrl;

  localparam int TD = 4;
  localparam int SEC = 2;
  localparam int TL = 3;
  localparam int WH = 2;
  localparam int LV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ball_round_if bus();

  ball_round_ctrl #(
    .TICK_DIV(TD), .SEC_TICKS(SEC), .TIME_LIMIT(TL), .WIN_HOLD(WH), .LEVELS(LV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tbl_ix[4] = '{40, 600, 320, 40};
  int tbl_iy[4] = '{40, 40, 40, 240};
  int tbl_sx[4] = '{600, 40, 320, 600};
  int tbl_sy[4] = '{440, 440, 440, 240};

  // The model keeps totals: run_cycles counts divider cycles since LOAD and ticks counts physics steps.
  // The timer is derived from the tick count by division rather than kept as separate counters.
  int m_state, m_level, m_run, m_ticks, m_hold, m_load;

  function automatic int m_time();
    int t;
    t = TL - m_ticks / SEC;
    return (t < 0) ? 0 : t;
  endfunction

  task automatic m_enter_load(input int lv);
    m_state = 1;
    m_level = lv;
    m_run   = 0;
    m_ticks = 0;
    m_hold  = 0;
    m_load  = 2;
  endtask

  task automatic m_step(input bit s, input bit p, input bit w);
    bit tick, sec_done;
    case (m_state)
      0: if (s) m_enter_load(0);
      1: begin
        m_load--;
        if (m_load == 0) m_state = 2;
      end
      2: begin
        tick = (m_run % TD == TD - 1);
        m_run++;
        sec_done = 1'b0;
        if (tick) begin
          m_ticks++;
          sec_done = (m_ticks % SEC == 0);
        end
        if (w)                              m_state = 4;
        else if (sec_done && m_time() == 0) m_state = 5;
        else if (p)                         m_state = 3;
      end
      3: if (!p) m_state = 2;
      4: begin
        tick = (m_run % TD == TD - 1);
        m_run++;
        if (tick) begin
          m_hold++;
          if (m_hold == WH) begin
            if (m_level == LV - 1) m_state = 6;
            else                   m_enter_load(m_level + 1);
          end
        end
      end
      5: if (s) m_enter_load(m_level);
      6: if (s) m_enter_load(0);
      default: m_state = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; m_level = 0; m_run = 0; m_ticks = 0; m_hold = 0; m_load = 0;
    end else begin
      m_step(bus.start, bus.pause, bus.win);
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    int ptick;
    ptick = (m_state == 2 && (m_run % TD == TD - 1)) ? 1 : 0;
    check_output("cmp_state",     bus.state,     m_state);
    check_output("cmp_level",     bus.level,     m_level);
    check_output("cmp_time_left", bus.time_left, m_time());
    check_output("cmp_phys_tick", bus.phys_tick, ptick);
    check_output("cmp_pos_rst_n", bus.pos_rst_n, (m_state <= 1) ? 0 : 1);
    check_output("cmp_game_over", bus.game_over, (m_state == 5 || m_state == 6) ? 1 : 0);
    check_output("cmp_init_x",    bus.init_x,    tbl_ix[m_level]);
    check_output("cmp_init_y",    bus.init_y,    tbl_iy[m_level]);
    check_output("cmp_score_x",   bus.score_x,   tbl_sx[m_level]);
    check_output("cmp_score_y",   bus.score_y,   tbl_sy[m_level]);
  endtask

  initial forever begin
    @(negedge clk);
    compare_model();
  end

  task automatic apply_stimulus(input bit s, input bit p, input bit w);
    bus.start = s;
    bus.pause = p;
    bus.win   = w;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    apply_stimulus(1, 0, 0);
    cyc(1);
    apply_stimulus(0, 0, 0);
  endtask

  task automatic wait_state(input int st, input int limit, input string name);
    int k;
    k = 0;
    while (bus.state != 3'(st) && k < limit) begin
      cyc(1);
      k++;
    end
    check_output(name, bus.state, st);
  endtask

  initial begin
    int k, n;
    apply_stimulus(0, 0, 0);
    #1 rst = 1'b1;
    cyc(3);
    check_output("rst_state", bus.state, 0);
    check_output("rst_pos_rst_n", bus.pos_rst_n, 0);
    check_output("rst_time_left", bus.time_left, 3);
    check_output("rst_level", bus.level, 0);
    check_output("rst_game_over", bus.game_over, 0);
    rst = 1'b0;
    cyc(1);

    // First round: two LOAD cycles, ticks every 4th cycle, then a timeout.
    pulse_start();
    check_output("load1_state", bus.state, 1);
    check_output("load1_pos_rst_n", bus.pos_rst_n, 0);
    cyc(1);
    check_output("load2_state", bus.state, 1);
    check_output("load2_pos_rst_n", bus.pos_rst_n, 0);
    cyc(1);
    check_output("play_state", bus.state, 2);
    check_output("model_pin_play", m_state, 2);
    check_output("play_pos_rst_n", bus.pos_rst_n, 1);
    check_output("lvl0_init_x", bus.init_x, 40);
    check_output("lvl0_init_y", bus.init_y, 40);
    check_output("lvl0_score_x", bus.score_x, 600);
    check_output("lvl0_score_y", bus.score_y, 440);
    check_output("play_time_left", bus.time_left, 3);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      check_output("tick_period", bus.phys_tick, (i % 4 == 3) ? 1 : 0);
    end
    check_output("time_after_8", bus.time_left, 2);
    check_output("model_pin_time2", m_time(), 2);
    cyc(4);
    check_output("time_after_16", bus.time_left, 1);
    cyc(7);
    check_output("pre_lose_state", bus.state, 2);
    cyc(1);
    check_output("lose_state", bus.state, 5);
    check_output("lose_game_over", bus.game_over, 1);
    check_output("lose_time_left", bus.time_left, 0);
    check_output("lose_phys_tick", bus.phys_tick, 0);

    // Restart at the same level, then win on a tick cycle so the hold lasts exactly 8 clocks.
    pulse_start();
    check_output("relose_state", bus.state, 1);
    check_output("relose_level", bus.level, 0);
    check_output("relose_time", bus.time_left, 3);
    cyc(2);
    check_output("q0_state", bus.state, 2);
    cyc(3);
    check_output("q3_tick", bus.phys_tick, 1);
    apply_stimulus(0, 0, 1);
    cyc(1);
    apply_stimulus(0, 0, 0);
    check_output("hold_state", bus.state, 4);
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      check_output("hold_stay", bus.state, 4);
      check_output("hold_no_tick", bus.phys_tick, 0);
    end
    cyc(1);
    check_output("lvl1_state", bus.state, 1);
    check_output("lvl1_level", bus.level, 1);
    check_output("lvl1_init_x", bus.init_x, 600);
    check_output("lvl1_init_y", bus.init_y, 40);
    check_output("lvl1_score_x", bus.score_x, 40);
    check_output("lvl1_score_y", bus.score_y, 440);
    check_output("lvl1_time", bus.time_left, 3);

    // Win at the last level leads to DONE.
    cyc(2);
    check_output("r0_state", bus.state, 2);
    cyc(3);
    apply_stimulus(0, 0, 1);
    cyc(1);
    apply_stimulus(0, 0, 0);
    cyc(8);
    check_output("done_state", bus.state, 6);
    check_output("done_game_over", bus.game_over, 1);
    check_output("model_pin_done", m_state, 6);
    pulse_start();
    check_output("done_restart_state", bus.state, 1);
    check_output("done_restart_level", bus.level, 0);

    // Pause for 10 cycles with the divider at 2, then resume partway through the period.
    cyc(2);
    check_output("s0_state", bus.state, 2);
    cyc(1);
    apply_stimulus(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check_output("pause_state", bus.state, 3);
      check_output("pause_no_tick", bus.phys_tick, 0);
      check_output("pause_time", bus.time_left, 3);
      if (i == 9) apply_stimulus(0, 0, 0);
    end
    cyc(1);
    check_output("resume_state", bus.state, 2);
    check_output("resume_tick0", bus.phys_tick, 0);
    cyc(1);
    check_output("resume_tick1", bus.phys_tick, 1);

    // Win arrives in the same cycle as the final decrement.
    k = 0;
    while (bus.time_left != 8'd1 && k < 100) begin cyc(1); k++; end
    check_output("reach_t1", bus.time_left, 1);
    n = 0; k = 0;
    while (n < 2 && k < 100) begin
      cyc(1); k++;
      if (bus.phys_tick) n++;
    end
    check_output("two_ticks", n, 2);
    apply_stimulus(0, 0, 1);
    cyc(1);
    apply_stimulus(0, 0, 0);
    check_output("final_win_state", bus.state, 4);
    check_output("final_win_time", bus.time_left, 0);
    check_output("final_win_game_over", bus.game_over, 0);
    wait_state(1, 20, "final_win_load");
    check_output("final_win_level", bus.level, 1);

    // Win and pause together, then an asynchronous reset partway through the hold.
    wait_state(2, 10, "wp_play");
    apply_stimulus(0, 1, 1);
    cyc(1);
    apply_stimulus(0, 0, 0);
    check_output("win_pause_state", bus.state, 4);
    cyc(3);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_state", bus.state, 0);
    check_output("async_rst_level", bus.level, 0);
    check_output("async_rst_pos_rst_n", bus.pos_rst_n, 0);
    check_output("async_rst_time", bus.time_left, 3);
    check_output("async_rst_tick", bus.phys_tick, 0);
    cyc(1);
    rst = 1'b0;

    // Random play. The win rate changes every 500 cycles so that some rounds time out.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #2;
      rst = ($urandom_range(0, 499) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      if ((i / 500) % 2 == 0) bus.win = ($urandom_range(0, 5) == 0);
      else                    bus.win = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    apply_stimulus(0, 0, 0);
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ball_round_ctrl.md
Name: ball_round_ctrl

Overview:
- Round sequencer for the balance-board ball physics block: owns that block's active-low reset, issues the physics step strobe, and supplies the start/target coordinates for each level.
- Counts down the round timer, advances levels on win, and declares loss on timeout.
- Sits between the button/debounce logic and the position/velocity datapath; also feeds the VGA/score display.

Parameters:
TICK_DIV, 1000000, clk cycles per physics step (phys_tick period); must be >= 2
SEC_TICKS, 100, phys_ticks per timer unit
TIME_LIMIT, 60, timer units per round (1..255)
WIN_HOLD, 150, phys-tick periods the ball is frozen on target after a win
LEVELS, 4, number of levels used from the table (1..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse, already debounced/synchronized
pause  in  1  level; high freezes play
win  in  1  from the physics block; high = ball reached target
phys_tick  out  1  one-cycle physics step enable
pos_rst_n  out  1  active-low reset to the physics/position block
init_x, init_y  out  11 each  start position for the current level
score_x, score_y  out  11 each  target position for the current level
level  out  2  current level index
time_left  out  8  remaining timer units
state  out  3  FSM state encoding (for display)
game_over  out  1  high in LOSE or DONE

Behaviour:
- Reset (rst=1, async) values:
  - state=IDLE, level=0, time_left=TIME_LIMIT.
  - pos_rst_n=0, phys_tick=0, game_over=0.
  - All counters 0.
- Level table, combinational from level, given as init(x,y) -> score(x,y):
  - 0: (40,40) -> (600,440)
  - 1: (600,40) -> (40,440)
  - 2: (320,40) -> (320,440)
  - 3: (40,240) -> (600,240)
- State encoding: IDLE=0, LOAD=1, PLAY=2, PAUSE=3, WIN_HOLD=4, LOSE=5, DONE=6.
- IDLE:
  - pos_rst_n=0.
  - start -> LOAD with level=0.
- LOAD:
  - pos_rst_n=0 for exactly 2 clk cycles.
  - time_left loaded with TIME_LIMIT; tick divider, sec counter and hold counter cleared.
  - Then -> PLAY.
- PLAY:
  - pos_rst_n=1.
  - Divider counts 0..TICK_DIV-1 and wraps.
  - phys_tick=1 in the cycle the divider equals TICK_DIV-1 (registered output).
  - Each phys_tick increments the sec counter.
  - When the sec counter reaches SEC_TICKS-1 on a tick, it wraps and time_left decrements.
  - Priority per cycle: win > timeout > pause.
    - win=1 -> WIN_HOLD.
    - The decrement that makes time_left==0 -> LOSE. A decrement and a win in the same cycle go to WIN_HOLD, with time_left still updated.
    - pause=1 -> PAUSE.
- PAUSE:
  - pos_rst_n=1, phys_tick=0.
  - Divider, sec counter and time_left frozen.
  - pause=0 -> PLAY, resuming from the frozen divider value.
  - win is ignored while in PAUSE.
- WIN_HOLD:
  - pos_rst_n=1, phys_tick=0. The physics block holds the ball on target by itself.
  - The divider keeps running. The hold counter increments on each divider wrap.
  - After WIN_HOLD wraps:
    - if level==LEVELS-1 -> DONE;
    - otherwise level increments and -> LOAD.
- LOSE:
  - game_over=1, pos_rst_n=1, phys_tick=0, time_left=0.
  - start -> LOAD at the same level.
- DONE:
  - game_over=1, phys_tick=0.
  - start -> LOAD with level=0.
- start is ignored in LOAD, PLAY, PAUSE and WIN_HOLD.
- rst asserted in any state returns all outputs to their reset values immediately, including mid-LOAD and mid-WIN_HOLD.
- phys_tick is never high while pos_rst_n=0.
- time_left never underflows (saturates at 0).
- level never exceeds LEVELS-1.
- Counter widths:
  - divider: clog2(TICK_DIV) bits.
  - sec counter and hold counter: 8 bits or clog2 of their parameter, whichever is larger.
- No combinational path from inputs to outputs, except the level-table lookup from the level register.

Test Plan:
- Bench parameters: TICK_DIV=4, SEC_TICKS=2, TIME_LIMIT=3, WIN_HOLD=2, LEVELS=2.
- Reset, then start pulse:
  - pos_rst_n low exactly 2 cycles, then state=PLAY;
  - init=(40,40), score=(600,440), time_left=3;
  - phys_tick high every 4th cycle.
- Timeout, no win:
  - time_left steps 3->2->1->0 every 8 clk;
  - on the cycle it reaches 0: state=LOSE, game_over=1, phys_tick stays 0;
  - start -> LOAD with level still 0.
- win pulsed in PLAY at level 0:
  - WIN_HOLD with no phys_tick for 8 clk;
  - then LOAD, level=1, init=(600,40), score=(40,440), time_left=3.
- win at level 1 (last level):
  - after hold, state=DONE, game_over=1;
  - start -> LOAD, level=0.
- pause high for 10 cycles mid-PLAY:
  - phys_tick=0 and time_left constant throughout;
  - after release, the first phys_tick arrives after the remaining divider count, not a full period.
- Corner cases:
  - win in the same cycle as the final decrement -> WIN_HOLD, not LOSE.
  - win and pause together -> WIN_HOLD.
  - rst pulsed mid-WIN_HOLD -> state=IDLE, level=0, pos_rst_n=0 asynchronously.
